// File: rtl/diff_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : diff_pkg
//  Description : Shared state encoding and default sizing for the differential
//                decoder.
//  Revision    : 1.0
// ============================================================================
package diff_pkg;

    localparam int c_DEF_WIDTH     = 4;
    localparam int c_DEF_FRAME_LEN = 8;
    localparam int c_CNT_W         = 8;

    typedef enum logic [0:0] {
        SEED = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/diff_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : diff_decoder_if
//  Description : Valid/ready input and output streams of the differential
//                decoder. The decoder takes the slave view.
//  Revision    : 1.0
// ============================================================================
interface diff_decoder_if
    import diff_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_s;
    logic             in_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_q;
    logic             out_last;
    logic             out_err;

    modport master (
        output in_valid, in_s, in_cout, out_ready,
        input  in_ready, out_valid, out_q, out_last, out_err
    );

    modport slave (
        input  in_valid, in_s, in_cout, out_ready,
        output in_ready, out_valid, out_q, out_last, out_err
    );

endinterface
`default_nettype wire

// File: rtl/diff_add.sv
`default_nettype none
// ============================================================================
//  Module      : diff_add
//  Description : Adds a difference to the previous sample and derives the
//                no-borrow flag the encoder's subtractor should have produced.
//  Revision    : 1.0
// ============================================================================
module diff_add
    import diff_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH
) (
    input  wire logic [WIDTH-1:0] i_prev,
    input  wire logic [WIDTH-1:0] i_diff,
    output logic      [WIDTH-1:0] o_sum,
    output logic                  o_nb_exp
);

    logic [WIDTH:0] w_sum;

    // A carry out means cur wrapped below prev, i.e. the subtractor borrowed.
    assign w_sum    = {1'b0, i_prev} + {1'b0, i_diff};
    assign o_sum    = w_sum[WIDTH-1:0];
    assign o_nb_exp = ~w_sum[WIDTH];

endmodule
`default_nettype wire

// File: rtl/diff_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : diff_decoder
//  Description : Rebuilds samples from a seed word followed by FRAME_LEN
//                modular differences, flagging inconsistent no-borrow bits.
//  Revision    : 1.0
// ============================================================================
module diff_decoder
    import diff_pkg::*;
#(
    parameter int WIDTH     = c_DEF_WIDTH,
    parameter int FRAME_LEN = c_DEF_FRAME_LEN
) (
    input  wire logic       clk,
    input  wire logic       rst,
    diff_decoder_if.slave   bus,
    input  wire logic       err_clr,
    output logic            err
);

    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(FRAME_LEN - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_prev;
    logic [WIDTH-1:0]   w_prev_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_valid;
    logic               r_last;
    logic               w_last_nxt;
    logic               r_oerr;
    logic               w_oerr_nxt;
    logic               r_err;
    logic               r_err_pend;
    logic               w_in_ready;
    logic               w_in_acc;
    logic [WIDTH-1:0]   w_sum;
    logic               w_nb_exp;

    assign w_in_ready = !r_valid || bus.out_ready;
    assign w_in_acc   = bus.in_valid && w_in_ready;

    diff_add #(
        .WIDTH (WIDTH)
    ) u_add (
        .i_prev   (r_prev),
        .i_diff   (bus.in_s),
        .o_sum    (w_sum),
        .o_nb_exp (w_nb_exp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_oerr_nxt  = r_oerr;
        if (w_in_acc) begin
            case (r_state)
                SEED: begin
                    w_prev_nxt  = bus.in_s;
                    w_last_nxt  = 1'b0;
                    w_oerr_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = RUN;
                end
                RUN: begin
                    w_prev_nxt = w_sum;
                    w_oerr_nxt = (bus.in_cout != w_nb_exp);
                    if (r_cnt == c_LAST_CNT) begin
                        w_last_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = SEED;
                    end else begin
                        w_last_nxt = 1'b0;
                        w_cnt_nxt  = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = SEED;
                end
            endcase
        end
    end

    // The output sample is also the reconstruction history, so one register
    // serves as both prev and out_q; it only changes on an accepted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev     <= '0;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_oerr     <= 1'b0;
            r_err_pend <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_prev     <= w_prev_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last     <= w_last_nxt;
            r_oerr     <= w_oerr_nxt;
            if (w_in_acc) begin
                r_valid <= 1'b1;
            end else if (bus.out_ready) begin
                r_valid <= 1'b0;
            end
            r_err_pend <= w_in_acc && (r_state == RUN) && w_oerr_nxt;
            r_err      <= r_err_pend || (r_err && !err_clr);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_q     = r_prev;
    assign bus.out_last  = r_last;
    assign bus.out_err   = r_oerr;
    assign err           = r_err;

endmodule
`default_nettype wire

// File: doc/diff_decoder.md
DIFF_DECODER -- requirements
Module: diff_decoder

Interface
REQ-001 Parameter WIDTH, default 4: sample and difference width in bits.
REQ-002 Parameter FRAME_LEN, default 8: number of difference words following each seed word; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_ready  output  1  decoder can accept a word this cycle.
REQ-007 in_s  input  WIDTH  seed value, or difference (cur - prev) mod 2^WIDTH.
REQ-008 in_cout  input  1  subtractor no-borrow flag: 1 when cur >= prev; ignored on seed words.
REQ-009 out_valid  output  1  reconstructed sample present.
REQ-010 out_ready  input  1  downstream accepts the sample.
REQ-011 out_q  output  WIDTH  reconstructed sample.
REQ-012 out_last  output  1  sample is the final difference of a frame.
REQ-013 out_err  output  1  in_cout was inconsistent for this sample.
REQ-014 err  output  1  sticky error, set by any out_err sample.
REQ-015 err_clr  input  1  clears err.

Function
REQ-016 The transfer rule SHALL be: in accepted when in_valid && in_ready; out accepted when out_valid && out_ready.
REQ-017 in_ready SHALL equal !out_valid || out_ready, combinationally, giving full throughput with no bubbles.
REQ-018 The FSM SHALL have states SEED and RUN, and SHALL be in SEED after reset.
REQ-019 An accepted word in SEED SHALL load prev and out_q with in_s, set out_err=0 and out_last=0, clear cnt to 0, and move to RUN.
REQ-020 An accepted word in RUN SHALL form sum = prev + in_s, WIDTH+1 bits wide, and load prev and out_q with sum[WIDTH-1:0].
REQ-021 In RUN, out_err SHALL be (in_cout != ~sum[WIDTH]); the sample SHALL still be emitted.
REQ-022 In RUN, out_last SHALL be 1 when cnt == FRAME_LEN-1. In that case the FSM SHALL return to SEED and clear cnt; otherwise cnt SHALL increment.
REQ-023 Latency SHALL be exactly 1 cycle from input acceptance to out_valid=1.
REQ-024 While out_valid && !out_ready, out_q, out_last and out_err SHALL hold stable and no input SHALL be accepted.
REQ-025 With no input accepted and out_ready=1, out_valid SHALL drop to 0 the following cycle.
REQ-026 Modular wrap SHALL be silent, with no saturation.
REQ-027 err SHALL set in the cycle after a sample with out_err=1 is loaded. When err_clr and a new error coincide, the set SHALL win.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL clear out_valid, out_q, out_last, out_err, err, prev and cnt, and SHALL set the state to SEED.
REQ-029 Reset mid-frame or with a held output SHALL discard the output and the frame; the next accepted word SHALL be treated as a seed.
REQ-030 in_ready SHALL be 1 during the cycle after reset, and out_valid SHALL be 0 in that cycle.

Structure
REQ-031 A shared package diff_pkg SHALL hold the state enum (SEED, RUN) and the default WIDTH and FRAME_LEN constants.
REQ-032 One combinational sub-module, diff_add, SHALL compute sum and the expected no-borrow flag; the FSM, counter and output register SHALL live in diff_decoder.
REQ-033 cnt SHALL be 8 bits wide.

Verification
REQ-034 Seed and zero difference: FRAME_LEN=4; seed 1000, then in_s=0000 with in_cout=1 -> out_q 1000, then 1000, with out_err=0.
REQ-035 Wrap without error: seed 1110, then in_s=0011 with in_cout=0 -> out_q 0001, out_err=0, err stays 0.
REQ-036 Inconsistent flag: seed 1110, then in_s=0011 with in_cout=1 -> out_q 0001 and out_err=1; err=1 the next cycle and stays 1 until err_clr.
REQ-037 Frame boundary: FRAME_LEN=4; seed 0011 then differences 0010 (cout 1) x4 -> out_q 0101, 0111, 1001, 1011.
  - The fourth sample has out_last=1.
  - The next word, 0100, is output as the seed 0100.
REQ-038 Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_q held, no word lost or duplicated after out_ready returns.
REQ-039 Mid-frame reset: rst pulsed after 2 differences -> all outputs 0; next word 0110 emitted as seed 0110 with out_err=0.
